dff_debounce_edge: RTL and testbench

//   Conditions one asynchronous, possibly bouncy 1-bit input (push-button or external

---
 rtl/dff_debounce_edge.sv | 91 +++++++++
 tb/tb_dff_debounce_edge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dff_debounce_edge.sv
// dff_debounce_edge: synchronize and debounce one raw input into a clean level, edge pulses and a rise counter
module dff_debounce_edge #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             d_in,
    input  logic             clr_cnt,
    output logic             q,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] cnt
);
    localparam int TW = $clog2(STABLE_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {LOW, LOW_PEND, HIGH, HIGH_PEND} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            s1_q, s2_q;
    logic            lvl_q, lvl_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        lvl_d   = lvl_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            LOW:
                if (s2_q) begin
                    state_d = LOW_PEND;
                    timer_d = TW'(1);
                end
            LOW_PEND:
                if (!s2_q) state_d = LOW;
                else if (timer_q == T_LAST) begin
                    state_d = HIGH;
                    lvl_d   = 1'b1;
                    rise_d  = 1'b1;
                end else timer_d = timer_q + TW'(1);
            HIGH:
                if (!s2_q) begin
                    state_d = HIGH_PEND;
                    timer_d = TW'(1);
                end
            HIGH_PEND:
                if (s2_q) state_d = HIGH;
                else if (timer_q == T_LAST) begin
                    state_d = LOW;
                    lvl_d   = 1'b0;
                    fall_d  = 1'b1;
                end else timer_d = timer_q + TW'(1);
            default: state_d = LOW;
        endcase
        // a clear coinciding with a rise still counts that rise
        cnt_d = (clr_cnt ? '0 : cnt_q) + CNT_W'(rise_d);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= LOW;
            timer_q <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            s1_q    <= d_in;
            s2_q    <= s1_q;
            lvl_q   <= lvl_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q    = lvl_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign cnt  = cnt_q;
endmodule

// File: tb/tb_dff_debounce_edge.sv
// tb_dff_debounce_edge: directed and random checks of the debouncer against a run-length reference model
module tb_dff_debounce_edge;
    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rstb = 1'b1;
    logic       d_in = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       q, rise, fall, q2, rise2, fall2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    int n_total = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dff_debounce_edge #(.STABLE_CYCLES(SC), .CNT_W(8)) u_dut (
        .clk(clk), .rstb(rstb), .d_in(d_in), .clr_cnt(clr_cnt),
        .q(q), .rise(rise), .fall(fall), .cnt(cnt)
    );

    dff_debounce_edge #(.STABLE_CYCLES(SC), .CNT_W(2)) u_dut2 (
        .clk(clk), .rstb(rstb), .d_in(d_in), .clr_cnt(clr_cnt),
        .q(q2), .rise(rise2), .fall(fall2), .cnt(cnt2)
    );

    // Reference: two-sample delay line, then count consecutive samples that disagree with the level
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_q = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    int   m_run = 0;
    int   m_cnt = 0;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_q = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
            m_run = 0; m_cnt = 0;
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_run = (m_s2 != m_q) ? m_run + 1 : 0;
            if (m_run == SC) begin
                m_q = ~m_q;
                m_rise = m_q;
                m_fall = ~m_q;
                m_run = 0;
            end
            m_cnt = (clr_cnt ? 0 : m_cnt) + int'(m_rise);
            m_s2 = m_s1;
            m_s1 = d_in;
        end
    end

    task automatic test_reset;
        d_in = 1'b1;
        #1 rstb = 1'b0;
        @(negedge clk);
        n_total++;
        if ({q, rise, cnt} !== 10'b0) $display("FAIL reset_hold got q=%b rise=%b cnt=%0d exp 0/0/0", q, rise, cnt);
        else n_pass++;
        #3 rstb = 1'b1;
        // the first edge after release is E0; the rise belongs to E0+5
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_total++;
            if ({q, rise, fall, cnt, q2, cnt2} !== {m_q, m_rise, m_fall, m_cnt[7:0], m_q, m_cnt[1:0]})
                $display("FAIL reset_model k=%0d got %b/%b/%b/%0d/%0d exp %b/%b/%b/%0d/%0d", k, q, rise, fall, cnt, cnt2, m_q, m_rise, m_fall, m_cnt[7:0], m_cnt[1:0]);
            else n_pass++;
            n_total++;
            if (rise !== (k == 5)) $display("FAIL reset_rise_time k=%0d got rise=%b exp %b", k, rise, k == 5);
            else n_pass++;
        end
        n_total++;
        if ({q, cnt} !== {1'b1, 8'd1}) $display("FAIL reset_after got q=%b cnt=%0d exp 1/1", q, cnt);
        else n_pass++;
    endtask

    task automatic test_fall;
        d_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_total++;
            if ({q, rise, fall, cnt, q2, cnt2} !== {m_q, m_rise, m_fall, m_cnt[7:0], m_q, m_cnt[1:0]})
                $display("FAIL fall_model k=%0d got %b/%b/%b/%0d/%0d exp %b/%b/%b/%0d/%0d", k, q, rise, fall, cnt, cnt2, m_q, m_rise, m_fall, m_cnt[7:0], m_cnt[1:0]);
            else n_pass++;
            n_total++;
            if ({fall, rise} !== {k == 5, 1'b0}) $display("FAIL fall_time k=%0d got fall=%b rise=%b exp %b/0", k, fall, rise, k == 5);
            else n_pass++;
        end
        n_total++;
        if ({q, cnt} !== {1'b0, 8'd1}) $display("FAIL fall_after got q=%b cnt=%0d exp 0/1", q, cnt);
        else n_pass++;
    endtask

    task automatic test_glitch;
        int seen = 0;
        for (int k = 0; k < 14; k++) begin
            d_in = (k < 2);
            @(negedge clk);
            seen += int'(rise);
            n_total++;
            if ({q, rise, fall, cnt, q2, cnt2} !== {m_q, m_rise, m_fall, m_cnt[7:0], m_q, m_cnt[1:0]})
                $display("FAIL glitch_model k=%0d got %b/%b/%b/%0d/%0d exp %b/%b/%b/%0d/%0d", k, q, rise, fall, cnt, cnt2, m_q, m_rise, m_fall, m_cnt[7:0], m_cnt[1:0]);
            else n_pass++;
        end
        n_total++;
        if (seen != 0 || {q, cnt} !== {1'b0, 8'd1}) $display("FAIL glitch got rises=%0d q=%b cnt=%0d exp 0/0/1", seen, q, cnt);
        else n_pass++;
    endtask

    task automatic test_bounce;
        int seen = 0;
        for (int k = 0; k < 4; k++) begin
            d_in = (k % 2 == 0);
            @(negedge clk);
            seen += int'(rise);
        end
        d_in = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            seen += int'(rise);
            n_total++;
            if ({q, rise, fall, cnt, q2, cnt2} !== {m_q, m_rise, m_fall, m_cnt[7:0], m_q, m_cnt[1:0]})
                $display("FAIL bounce_model k=%0d got %b/%b/%b/%0d/%0d exp %b/%b/%b/%0d/%0d", k, q, rise, fall, cnt, cnt2, m_q, m_rise, m_fall, m_cnt[7:0], m_cnt[1:0]);
            else n_pass++;
            n_total++;
            if (rise !== (k == 5)) $display("FAIL bounce_rise_time k=%0d got rise=%b exp %b", k, rise, k == 5);
            else n_pass++;
        end
        n_total++;
        if (seen != 1 || cnt !== 8'd2) $display("FAIL bounce_count got rises=%0d cnt=%0d exp 1/2", seen, cnt);
        else n_pass++;
        d_in = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_wrap;
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 16; k++) begin
                d_in = (k < 8);
                @(negedge clk);
                n_total++;
                if ({q, rise, fall, cnt, q2, cnt2} !== {m_q, m_rise, m_fall, m_cnt[7:0], m_q, m_cnt[1:0]})
                    $display("FAIL wrap_model p=%0d k=%0d got %b/%b/%b/%0d/%0d exp %b/%b/%b/%0d/%0d", p, k, q, rise, fall, cnt, cnt2, m_q, m_rise, m_fall, m_cnt[7:0], m_cnt[1:0]);
                else n_pass++;
            end
            n_total++;
            if (cnt2 !== 2'((p + 1) % 4)) $display("FAIL wrap_cnt2 p=%0d got %0d exp %0d", p, cnt2, (p + 1) % 4);
            else n_pass++;
        end
        // clear lands on the same edge as the fifth rise
        d_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            clr_cnt = (k == 4);
            if (k == 5) begin
                n_total++;
                if ({rise, cnt, cnt2} !== {1'b1, 8'd1, 2'd1}) $display("FAIL clr_with_rise got rise=%b cnt=%0d cnt2=%0d exp 1/1/1", rise, cnt, cnt2);
                else n_pass++;
            end
        end
        d_in = 1'b0;
        repeat (8) @(negedge clk);
        n_total++;
        if ({q, cnt} !== {1'b0, 8'd1}) $display("FAIL wrap_end got q=%b cnt=%0d exp 0/1", q, cnt);
        else n_pass++;
    endtask

    task automatic test_mid_reset;
        d_in = 1'b1;
        repeat (4) @(negedge clk);
        #1 rstb = 1'b0;
        #1;
        n_total++;
        if ({q, rise, fall, cnt, cnt2} !== 13'b0) $display("FAIL midreset_now got q=%b rise=%b fall=%b cnt=%0d cnt2=%0d exp all 0", q, rise, fall, cnt, cnt2);
        else n_pass++;
        #1 rstb = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_total++;
            if ({q, rise, fall, cnt, q2, cnt2} !== {m_q, m_rise, m_fall, m_cnt[7:0], m_q, m_cnt[1:0]})
                $display("FAIL midreset_model k=%0d got %b/%b/%b/%0d/%0d exp %b/%b/%b/%0d/%0d", k, q, rise, fall, cnt, cnt2, m_q, m_rise, m_fall, m_cnt[7:0], m_cnt[1:0]);
            else n_pass++;
            n_total++;
            if (rise !== (k == 5)) $display("FAIL midreset_rise_time k=%0d got rise=%b exp %b", k, rise, k == 5);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        for (int s = 0; s < 80; s++) begin
            d_in = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 8)) begin
                clr_cnt = ($urandom_range(0, 7) == 0);
                @(negedge clk);
                n_total++;
                if ({q, rise, fall, cnt, q2, cnt2} !== {m_q, m_rise, m_fall, m_cnt[7:0], m_q, m_cnt[1:0]} || (rise && fall))
                    $display("FAIL random s=%0d got %b/%b/%b/%0d/%0d exp %b/%b/%b/%0d/%0d", s, q, rise, fall, cnt, cnt2, m_q, m_rise, m_fall, m_cnt[7:0], m_cnt[1:0]);
                else n_pass++;
            end
        end
        clr_cnt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fall();
        test_glitch();
        test_bounce();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
